shift_register: RTL and testbench
=================================

SHIFT_REGISTER -- requirements
Module: shift_register

Interface
REQ-001 Parameter WIDTH, default 8: register length in bits; legal range 2..64.
REQ-002 Parameter SHIFT_LEFT, default 1: 1 = new bit enters out[0] and data moves toward out[WIDTH-1]; 0 = new bit enters out[WIDTH-1] and data moves toward out[0].
REQ-003 Parameter RESET_VAL, default all-zeros (WIDTH bits): value loaded into the register by reset.
REQ-004 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-low reset; sampled only on the rising edge of clk.
REQ-006 Port in, input, 1 bit: serial data input, sampled on every rising edge of clk.
REQ-007 Port out, output, WIDTH bits: parallel contents of the shift register, driven directly from flops.

Function
REQ-008 The block SHALL be a serial-in, parallel-out shift register with exactly one storage element per bit of out.
REQ-009 The block SHALL update state only on the rising edge of clk, with no other clock, gated clock or latch.
REQ-010 When reset is 0 at a rising edge, out SHALL become RESET_VAL on that edge, and in SHALL be ignored.
REQ-011 When reset is 1 at a rising edge and SHIFT_LEFT=1, out SHALL become {out[WIDTH-2:0], in}.
REQ-012 When reset is 1 at a rising edge and SHIFT_LEFT=0, out SHALL become {in, out[WIDTH-1:1]}.
REQ-013 Latency: a bit sampled on in SHALL appear at the entry bit of out immediately after the same edge.
REQ-014 That bit SHALL reach the far-end bit after WIDTH-1 further edges.
REQ-015 On the following edge, that bit SHALL be discarded.
REQ-016 The block SHALL shift on every non-reset edge; it has no enable and no hold state.
REQ-017 The oldest bit SHALL be dropped every cycle, with no wrap-around and no overflow indication.
REQ-018 out SHALL be a pure register output, with no combinational path from in or reset to out.
REQ-019 Changes on reset or in between clock edges SHALL have no effect on out.

Reset
REQ-020 Reset SHALL be synchronous and active-low, with reset priority over shifting.
REQ-021 Reset asserted mid-stream SHALL discard all shifted data and load RESET_VAL on the same edge.
REQ-022 On the first edge after reset deasserts (reset=1), the register SHALL shift in from RESET_VAL.
REQ-023 Before the first edge with reset=0, out is undefined, and the bench SHALL NOT check out in that interval.
REQ-024 The block SHALL NOT use any initial-value constructs; the reset path is the only initialisation.

Verification (defaults: WIDTH=8, SHIFT_LEFT=1, RESET_VAL=0 unless stated)
REQ-025 Reset check: hold reset=0 for 2 edges with in=1 -> out=8'h00 after each of those edges.
REQ-026 Single-bit walk: reset, then in=1 for 1 edge and in=0 for 8 edges -> out steps 01,02,04,...,80, then 00.
REQ-027 Fill check: reset, then in=1 for 8 edges -> out steps 01,03,07,...,FF, and holds FF while in stays 1.
REQ-028 Reset mid-operation: load 8'hA5 serially (MSB first), then hold reset=0 for 1 edge -> out=8'h00 on that edge, and shifting resumes from 00 on the next edge.
REQ-029 Asynchronous-immunity check: pulse reset=0 and toggle in strictly between edges -> out unchanged until the next edge samples the values present then.
REQ-030 Parameter variant: WIDTH=4, SHIFT_LEFT=0, RESET_VAL=4'hF; reset, then in=0 for 4 edges -> out steps 7,3,1,0.

Source files
------------

// File: rtl/shift_register.sv
// shift_register: serial-in parallel-out shift register with synchronous active-low reset
module shift_register #(
  parameter int              WIDTH      = 8,
  parameter bit              SHIFT_LEFT = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  output logic [WIDTH-1:0] out
);
  always_ff @(posedge clk)
    out <= !reset ? RESET_VAL : SHIFT_LEFT ? {out[WIDTH-2:0], in} : {in, out[WIDTH-1:1]};
endmodule

// File: tb/tb_shift_register.sv
// tb_shift_register: scoreboard bench for default and right-shifting preset variants
module tb_shift_register;
  logic clk = 1'b0;
  logic reset_a = 1'b0, in_a = 1'b0;
  logic reset_b = 1'b0, in_b = 1'b0;
  logic [7:0] out_a;
  logic [3:0] out_b;
  logic [7:0] sb_a[$];
  logic [3:0] sb_b[$];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  shift_register dut_a (.clk(clk), .reset(reset_a), .in(in_a), .out(out_a));
  shift_register #(.WIDTH(4), .SHIFT_LEFT(1'b0), .RESET_VAL(4'hF))
    dut_b (.clk(clk), .reset(reset_b), .in(in_b), .out(out_b));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step_a(input logic r, input logic i, input logic [7:0] e, input string tag);
    reset_a = r;
    in_a = i;
    sb_a.push_back(e);
    @(posedge clk);
    #1;
    check(tag, 64'(out_a), 64'(sb_a.pop_front()));
  endtask
  task automatic step_b(input logic r, input logic i, input logic [3:0] e, input string tag);
    reset_b = r;
    in_b = i;
    sb_b.push_back(e);
    @(posedge clk);
    #1;
    check(tag, 64'(out_b), 64'(sb_b.pop_front()));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] pat;
    pat = 8'hA5;
    @(negedge clk);
    step_a(1'b0, 1'b1, 8'h00, "reset0");
    step_a(1'b0, 1'b1, 8'h00, "reset1");
    step_a(1'b1, 1'b1, 8'h01, "walk0");
    for (int k = 1; k < 8; k++) step_a(1'b1, 1'b0, 8'(16'd1 << k), "walk");
    step_a(1'b1, 1'b0, 8'h00, "walk_out");
    step_a(1'b0, 1'b0, 8'h00, "fill_rst");
    for (int k = 0; k < 8; k++) step_a(1'b1, 1'b1, 8'((16'd2 << k) - 16'd1), "fill");
    step_a(1'b1, 1'b1, 8'hFF, "fill_hold0");
    step_a(1'b1, 1'b1, 8'hFF, "fill_hold1");
    step_a(1'b0, 1'b0, 8'h00, "mid_rst0");
    for (int k = 7; k >= 0; k--) step_a(1'b1, pat[k], 8'(pat >> k), "load_a5");
    step_a(1'b0, 1'b1, 8'h00, "mid_rst");
    step_a(1'b1, 1'b1, 8'h01, "resume");
    #2 reset_a = 1'b0; in_a = 1'b0;
    #1 check("async_hold0", 64'(out_a), 64'h01);
    #1 in_a = 1'b1; reset_a = 1'b1;
    step_a(1'b1, 1'b0, 8'h02, "async_edge0");
    #2 reset_a = 1'b0; in_a = 1'b0;
    #1 check("async_hold1", 64'(out_a), 64'h02);
    #1 reset_a = 1'b1;
    step_a(1'b1, 1'b1, 8'h05, "async_edge1");
    step_b(1'b0, 1'b0, 4'hF, "v_reset");
    step_b(1'b1, 1'b0, 4'h7, "v_shift0");
    step_b(1'b1, 1'b0, 4'h3, "v_shift1");
    step_b(1'b1, 1'b0, 4'h1, "v_shift2");
    step_b(1'b1, 1'b0, 4'h0, "v_shift3");
    step_b(1'b1, 1'b1, 4'h8, "v_entry");
    step_b(1'b1, 1'b0, 4'h4, "v_move");
    check("sb_empty", 64'(sb_a.size() + sb_b.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
